// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: steps an 8-bit LED pattern chosen by the DIP
// switches. The push keys control run/pause, single-step and speed. The
// LED output can be inverted or blanked without disturbing the sequence.
module led_pattern_sequencer #(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic       iSysClk,
    input  logic       iSysRst,
    input  logic [3:0] iUserDipSw,
    input  logic [3:0] iUserPushSw,
    output logic [7:0] oUserLed,
    output logic       oStepPulse,
    output logic       oRunning
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // One extra bit so that a power-of-two TICK_DIV fits as a period value.
    localparam logic [CNT_W:0] TICK_FULL = (CNT_W + 1)'(TICK_DIV);
    localparam logic [CNT_W:0] ONE       = {{CNT_W{1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic             resume_run;   // state LOAD returns to: 1=RUN, 0=PAUSE
    logic [1:0]       pat_sel;
    logic [7:0]       pattern;
    logic             dir_right;
    logic [1:0]       speed;
    logic [CNT_W-1:0] count;
    logic [3:0]       push_prev;

    logic [3:0]       press;
    logic             pat_change;
    logic             speed_up;
    logic             speed_down;
    logic             speed_change;
    logic [CNT_W:0]   period;
    logic [CNT_W:0]   last;
    logic             terminal;
    logic             do_load;
    logic             do_advance;
    logic [8:0]       adv_next;

    // Starting value of each pattern.
    function automatic logic [7:0] seed_of(input logic [1:0] sel);
        logic [7:0] s;
        case (sel)
            2'd0:    s = 8'h00;
            2'd1:    s = 8'h01;
            2'd2:    s = 8'h01;
            default: s = 8'h55;
        endcase
        return s;
    endfunction

    // Next pattern value; bit 8 of the result is the new ping-pong direction.
    function automatic logic [8:0] advance_of(input logic [1:0] sel,
                                              input logic [7:0] pat,
                                              input logic       dir_r);
        logic [7:0] nxt;
        logic       nd;
        nxt = pat;
        nd  = dir_r;
        case (sel)
            2'd0: nxt = pat + 8'd1;
            2'd1: nxt = {pat[6:0], pat[7]};
            2'd2: begin
                if (!dir_r) begin
                    if (pat == 8'h80) begin
                        nxt = 8'h40;
                        nd  = 1'b1;
                    end else begin
                        nxt = pat << 1;
                    end
                end else begin
                    if (pat == 8'h01) begin
                        nxt = 8'h02;
                        nd  = 1'b0;
                    end else begin
                        nxt = pat >> 1;
                    end
                end
            end
            default: nxt = ~pat;
        endcase
        return {nd, nxt};
    endfunction

    // Key edges, speed decode, prescaler terminal count and next state.
    always_comb begin
        press        = iUserPushSw & ~push_prev;
        pat_change   = (iUserDipSw[1:0] != pat_sel);
        speed_up     = press[2] & ~press[3] & (speed != 2'd3);
        speed_down   = press[3] & ~press[2] & (speed != 2'd0);
        speed_change = speed_up | speed_down;
        period       = TICK_FULL >> {speed, 1'b0};
        if (period == '0) begin
            period = ONE;
        end
        last         = period - ONE;
        terminal     = ({1'b0, count} == last);
        adv_next     = advance_of(pat_sel, pattern, dir_right);
        state_next   = state;
        do_load      = 1'b0;
        do_advance   = 1'b0;
        if (pat_change) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    do_load    = 1'b1;
                    state_next = resume_run ? RUN : PAUSE;
                end
                RUN: begin
                    if (press[0]) begin
                        state_next = PAUSE;
                    end else if (terminal && !speed_change) begin
                        do_advance = 1'b1;
                    end
                end
                PAUSE: begin
                    if (press[0]) begin
                        state_next = RUN;
                    end else if (press[1]) begin
                        do_advance = 1'b1;
                    end
                end
                default: state_next = LOAD;
            endcase
        end
    end

    // State register; remember where LOAD should return to.
    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            state      <= LOAD;
            resume_run <= 1'b1;
        end else begin
            state <= state_next;
            if (pat_change && state != LOAD) begin
                resume_run <= (state == RUN);
            end
        end
    end

    // Key history, pattern select, speed level and prescaler.
    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            push_prev <= 4'hF;
            pat_sel   <= 2'd0;
            speed     <= 2'd0;
            count     <= '0;
        end else begin
            push_prev <= iUserPushSw;
            if (pat_change) begin
                pat_sel <= iUserDipSw[1:0];
            end
            if (speed_up) begin
                speed <= speed + 2'd1;
            end else if (speed_down) begin
                speed <= speed - 2'd1;
            end
            // Counter only runs while staying in RUN at an unchanged speed.
            if (state == RUN && state_next == RUN && !speed_change) begin
                count <= terminal ? '0 : count + 1'b1;
            end else begin
                count <= '0;
            end
        end
    end

    // Pattern register: seeded on LOAD, stepped on advance.
    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            pattern   <= 8'h00;
            dir_right <= 1'b0;
        end else if (do_load) begin
            pattern   <= seed_of(pat_sel);
            dir_right <= 1'b0;
        end else if (do_advance) begin
            pattern   <= adv_next[7:0];
            dir_right <= adv_next[8];
        end
    end

    // Registered outputs: LED drive with modifiers, step pulse, run flag.
    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            oUserLed   <= 8'h00;
            oStepPulse <= 1'b0;
            oRunning   <= 1'b0;
        end else begin
            oUserLed   <= iUserDipSw[3] ? 8'h00 : (pattern ^ {8{iUserDipSw[2]}});
            oStepPulse <= do_advance;
            oRunning   <= (state_next == RUN);
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed scenarios plus random keys and
// DIP changes, all checked cycle by cycle against a behavioural model.
module tb_led_pattern_sequencer;

    localparam int TICK_DIV = 8;

    logic       clk;
    logic       rst;
    logic [3:0] dip;
    logic [3:0] push;
    logic [7:0] led;
    logic       step_pulse;
    logic       running;

    int n_checks;
    int n_fail;
    int dut_pulses;
    int mdl_pulses;

    // Behavioural model state
    bit         m_paused;
    bit         m_load;
    int         m_sel;
    int         m_val;
    int         m_phase;
    int         m_speed;
    int         m_cnt;
    logic [3:0] m_prev;

    logic [7:0] pp_tab [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                8'h02};

    led_pattern_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .iSysClk    (clk),
        .iSysRst    (rst),
        .iUserDipSw (dip),
        .iUserPushSw(push),
        .oUserLed   (led),
        .oStepPulse (step_pulse),
        .oRunning   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_paused = 0;
        m_load   = 1;
        m_sel    = 0;
        m_val    = 0;
        m_phase  = 0;
        m_speed  = 0;
        m_cnt    = 0;
        m_prev   = 4'hF;
    endtask

    function automatic int seed_val(input int sel);
        case (sel)
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h01;
            default: return 8'h55;
        endcase
    endfunction

    // Ping-pong is a 14-step cycle of bit positions 0..7..1.
    task automatic model_advance();
        case (m_sel)
            0: m_val = (m_val + 1) % 256;
            1: m_val = ((m_val << 1) | (m_val >> 7)) & 255;
            2: begin
                m_phase = (m_phase + 1) % 14;
                m_val   = 1 << ((m_phase <= 7) ? m_phase : 14 - m_phase);
            end
            default: m_val = 255 - m_val;
        endcase
    endtask

    // One clock of the model with the inputs about to be sampled.
    task automatic model_step(output logic [7:0] e_led, output logic e_pulse,
                              output logic e_run);
        logic [3:0] pr;
        int per;
        bit up, dn, chg;
        pr     = push & ~m_prev;
        m_prev = push;
        up     = pr[2] && !pr[3] && m_speed < 3;
        dn     = pr[3] && !pr[2] && m_speed > 0;
        chg    = up || dn;
        per    = TICK_DIV / (1 << (2 * m_speed));
        if (per < 1) per = 1;
        e_led   = dip[3] ? 8'h00 : (8'(m_val) ^ {8{dip[2]}});
        e_pulse = 1'b0;
        if (int'(dip[1:0]) != m_sel) begin
            m_sel  = int'(dip[1:0]);
            m_load = 1;
            m_cnt  = 0;
        end else if (m_load) begin
            m_load  = 0;
            m_val   = seed_val(m_sel);
            m_phase = 0;
            m_cnt   = 0;
        end else if (!m_paused) begin
            if (pr[0]) begin
                m_paused = 1;
                m_cnt    = 0;
            end else if (chg) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt >= per) begin
                    m_cnt = 0;
                    model_advance();
                    e_pulse = 1'b1;
                end
            end
        end else begin
            if (pr[0]) begin
                m_paused = 0;
                m_cnt    = 0;
            end else if (pr[1]) begin
                model_advance();
                e_pulse = 1'b1;
            end
        end
        if (up) m_speed++;
        if (dn) m_speed--;
        e_run = !m_load && !m_paused;
    endtask

    task automatic tick();
        logic [7:0] e_led;
        logic e_pulse, e_run;
        model_step(e_led, e_pulse, e_run);
        @(posedge clk);
        #1;
        if (step_pulse) dut_pulses++;
        if (e_pulse) mdl_pulses++;
        chk("led", {24'd0, led}, {24'd0, e_led});
        chk("step_pulse", {31'd0, step_pulse}, {31'd0, e_pulse});
        chk("running", {31'd0, running}, {31'd0, e_run});
    endtask

    task automatic press_keys(input logic [3:0] k);
        push = k;
        tick();
        push = 4'h0;
        tick();
    endtask

    task automatic wait_pulse(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (step_pulse) begin
                n = i;
                break;
            end
        end
        if (n < 0) chk("pulse_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int p0;
        n_checks = 0;
        n_fail = 0;
        dut_pulses = 0;
        mdl_pulses = 0;
        rst = 1'b1;
        dip = 4'h0;
        push = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        chk("reset_led", {24'd0, led}, 32'h00);
        chk("reset_running", {31'd0, running}, 32'd0);
        chk("reset_pulse", {31'd0, step_pulse}, 32'd0);
        rst = 1'b0;

        // Binary count from reset, through the FF -> 00 wrap.
        tick();
        chk("run_after_load", {31'd0, running}, 32'd1);
        wait_pulse(n);
        chk("first_step_latency", n, 32'd8);
        tick();
        chk("bin_first", {24'd0, led}, 32'h01);
        for (int i = 0; i < 254; i++) wait_pulse(n);
        chk("bin_spacing", n, 32'd8);
        tick();
        chk("bin_ff", {24'd0, led}, 32'hFF);
        wait_pulse(n);
        tick();
        chk("bin_wrap", {24'd0, led}, 32'h00);

        // Ping-pong through both direction flips.
        dip = 4'h2;
        tick();
        tick();
        tick();
        chk("pp_seed", {24'd0, led}, 32'h01);
        for (int i = 0; i < 15; i++) begin
            wait_pulse(n);
            tick();
            chk("pp_seq", {24'd0, led}, {24'd0, pp_tab[i]});
        end

        // Speed keys.
        press_keys(4'b0100);
        wait_pulse(n);
        wait_pulse(n);
        chk("spacing_speed1", n, 32'd2);
        press_keys(4'b0100);
        wait_pulse(n);
        wait_pulse(n);
        chk("spacing_speed_min_period", n, 32'd1);
        press_keys(4'b1000);
        press_keys(4'b1000);
        press_keys(4'b1000);
        wait_pulse(n);
        wait_pulse(n);
        chk("spacing_back_to_slow", n, 32'd8);
        press_keys(4'b1100);
        wait_pulse(n);
        wait_pulse(n);
        chk("spacing_both_keys", n, 32'd8);

        // Pause, single step, resume.
        dip = 4'h0;
        tick();
        tick();
        press_keys(4'b0001);
        chk("paused", {31'd0, running}, 32'd0);
        p0 = dut_pulses;
        repeat (100) tick();
        chk("frozen_pulses", dut_pulses - p0, 32'd0);
        p0 = dut_pulses;
        press_keys(4'b0010);
        press_keys(4'b0010);
        press_keys(4'b0010);
        chk("three_steps", dut_pulses - p0, 32'd3);
        p0 = dut_pulses;
        press_keys(4'b0011);
        chk("resume_running", {31'd0, running}, 32'd1);
        chk("resume_no_step", dut_pulses - p0, 32'd0);

        // Pattern change while paused.
        press_keys(4'b0001);
        dip = 4'h3;
        tick();
        tick();
        tick();
        chk("alt_seed", {24'd0, led}, 32'h55);
        chk("alt_stays_paused", {31'd0, running}, 32'd0);
        press_keys(4'b0010);
        chk("alt_step", {24'd0, led}, 32'hAA);

        // Modifiers.
        dip = 4'h1;
        repeat (3) tick();
        chk("rot_seed", {24'd0, led}, 32'h01);
        dip = 4'h5;
        tick();
        chk("invert", {24'd0, led}, 32'hFE);
        dip = 4'h9;
        tick();
        press_keys(4'b0001);
        p0 = dut_pulses;
        n = mdl_pulses;
        repeat (40) tick();
        chk("blank_led", {24'd0, led}, 32'h00);
        chk("blank_pulses", dut_pulses - p0, mdl_pulses - n);

        // Random keys and DIP changes.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) dip = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) push = 4'($urandom_range(0, 15));
            tick();
        end
        chk("random_pulse_total", dut_pulses, mdl_pulses);

        // Asynchronous reset mid-run.
        push = 4'h0;
        dip = 4'h1;
        repeat (4) tick();
        if (m_paused) press_keys(4'b0001);
        repeat (20) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led", {24'd0, led}, 32'h00);
        chk("async_rst_running", {31'd0, running}, 32'd0);
        @(posedge clk);
        #1;
        push = 4'b0001;
        model_reset();
        rst = 1'b0;
        repeat (20) tick();
        chk("held_key_no_pause", {31'd0, running}, 32'd1);
        push = 4'h0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
